// File: rtl/core_dmem_slave.sv
// Data-side memory responder: word RAM behind the core data port.
// Ports: clk/rst, mem_req/wen/waddr/wdata/raddr in, mem_rdata/hold_flag/err out.
module core_dmem_slave #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned WAIT_CYC  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter logic [31:0] ADDR_MASK = 32'h0000_3FFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_i,
   input  logic        mem_wen_i,
   input  logic [31:0] mem_waddr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [31:0] mem_raddr_i,
   output logic [31:0] mem_rdata_o,
   output logic        hold_flag_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   localparam bit NO_WAIT = (WAIT_CYC == 0);
   localparam logic [3:0] WCNT_INIT =
      NO_WAIT ? 4'd0 : 4'(WAIT_CYC - 1);

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic        ram_we;

   logic [31:0] ram_q [0:(1<<ADDR_W)-1];

   logic              w_hit, r_hit;
   logic [ADDR_W-1:0] w_idx, r_idx;

   assign w_hit = (mem_waddr_i & ~ADDR_MASK) == BASE_ADDR;
   assign r_hit = (mem_raddr_i & ~ADDR_MASK) == BASE_ADDR;
   assign w_idx = mem_waddr_i[ADDR_W+1:2];
   assign r_idx = mem_raddr_i[ADDR_W+1:2];

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      data_d      = data_q;
      err_d       = 1'b0;
      ram_we      = 1'b0;
      hold_flag_o = 1'b0;
      mem_rdata_o = 32'h0;
      unique case (state_q)
         S_IDLE: begin
            if (mem_req_i) begin
               if (mem_wen_i) begin
                  ram_we = w_hit;
                  err_d  = ~w_hit;
               end else if (r_hit) begin
                  // stall the core in the request cycle itself
                  hold_flag_o = 1'b1;
                  data_d      = ram_q[r_idx];
                  if (NO_WAIT) begin
                     state_d = S_RESP;
                  end else begin
                     state_d = S_WAIT;
                     wcnt_d  = WCNT_INIT;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            hold_flag_o = 1'b1;
            err_d       = mem_req_i & mem_wen_i;
            if (wcnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // the request still on the bus is the one completing now
            mem_rdata_o = data_q;
            err_d       = mem_req_i & mem_wen_i;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= 4'd0;
         data_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we && !rst) begin
         ram_q[w_idx] <= mem_wdata_i;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_core_dmem_slave.sv
// Bench for core_dmem_slave: three instances with 0, 1 and 3 wait cycles.
// Ports driven per instance; outputs checked against a map-based model.
module tb_core_dmem_slave;

   logic        clk;
   logic        rst   [3];
   logic        req   [3];
   logic        wen   [3];
   logic [31:0] waddr [3];
   logic [31:0] wdata [3];
   logic [31:0] raddr [3];
   logic [31:0] rdata [3];
   logic        hold  [3];
   logic        err   [3];

   int vectors = 0;
   int miscmp  = 0;

   int          wt [3] = '{0, 1, 3};
   logic [31:0] ref_mem [int];
   logic        exp_err [3];
   logic        nxt_err [3];

   core_dmem_slave #(.WAIT_CYC(0)) u0 (
      .clk(clk), .rst(rst[0]),
      .mem_req_i(req[0]), .mem_wen_i(wen[0]),
      .mem_waddr_i(waddr[0]), .mem_wdata_i(wdata[0]),
      .mem_raddr_i(raddr[0]), .mem_rdata_o(rdata[0]),
      .hold_flag_o(hold[0]), .err_o(err[0])
   );

   core_dmem_slave #(.WAIT_CYC(1)) u1 (
      .clk(clk), .rst(rst[1]),
      .mem_req_i(req[1]), .mem_wen_i(wen[1]),
      .mem_waddr_i(waddr[1]), .mem_wdata_i(wdata[1]),
      .mem_raddr_i(raddr[1]), .mem_rdata_o(rdata[1]),
      .hold_flag_o(hold[1]), .err_o(err[1])
   );

   core_dmem_slave #(.WAIT_CYC(3)) u2 (
      .clk(clk), .rst(rst[2]),
      .mem_req_i(req[2]), .mem_wen_i(wen[2]),
      .mem_waddr_i(waddr[2]), .mem_wdata_i(wdata[2]),
      .mem_raddr_i(raddr[2]), .mem_rdata_o(rdata[2]),
      .hold_flag_o(hold[2]), .err_o(err[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit in_rng(logic [31:0] a);
      return (a & ~32'h0000_3FFF) == 32'h1000_0000;
   endfunction

   function automatic int key(int k, logic [31:0] a);
      return k * 4096 + int'(a[13:2]);
   endfunction

   // one bus cycle: check outputs mid-cycle, then advance past the edge
   task automatic cyc(int k, logic eh, logic [31:0] ed, string tag);
      @(negedge clk);
      vectors++;
      assert (hold[k] === eh) else begin
         miscmp++;
         $error("FAIL %s/u%0d hold: observed %b expected %b",
                tag, k, hold[k], eh);
      end
      vectors++;
      assert (rdata[k] === ed) else begin
         miscmp++;
         $error("FAIL %s/u%0d rdata: observed %h expected %h",
                tag, k, rdata[k], ed);
      end
      vectors++;
      assert (err[k] === exp_err[k]) else begin
         miscmp++;
         $error("FAIL %s/u%0d err: observed %b expected %b",
                tag, k, err[k], exp_err[k]);
      end
      @(posedge clk);
      exp_err[k] = nxt_err[k];
      nxt_err[k] = 1'b0;
      #1;
   endtask

   task automatic idle(int k, int n);
      req[k] = 1'b0;
      wen[k] = 1'b0;
      for (int i = 0; i < n; i++) cyc(k, 1'b0, 32'h0, "idle");
   endtask

   task automatic wr(int k, logic [31:0] a, logic [31:0] d);
      req[k]   = 1'b1;
      wen[k]   = 1'b1;
      waddr[k] = a;
      wdata[k] = d;
      raddr[k] = 32'h0;
      if (in_rng(a)) ref_mem[key(k, a)] = d;
      else nxt_err[k] = 1'b1;
      cyc(k, 1'b0, 32'h0, "wr");
      req[k] = 1'b0;
      wen[k] = 1'b0;
   endtask

   // keep: request stays up after completion; bad: write shown while stalled
   task automatic rd(int k, logic [31:0] a, bit keep, bit bad);
      bit          hit;
      logic [31:0] ev;
      hit = in_rng(a);
      ev  = hit ? ref_mem[key(k, a)] : 32'h0;
      req[k]   = 1'b1;
      wen[k]   = 1'b0;
      raddr[k] = a;
      if (!hit) nxt_err[k] = 1'b1;
      cyc(k, hit, 32'h0, "rd_req");
      if (hit) begin
         for (int i = 1; i <= wt[k]; i++) begin
            if (bad && i == 1) begin
               wen[k]     = 1'b1;
               waddr[k]   = a;
               wdata[k]   = ~ev;
               nxt_err[k] = 1'b1;
            end else begin
               wen[k] = 1'b0;
            end
            cyc(k, 1'b1, 32'h0, "rd_wait");
         end
         if (bad && wt[k] == 0) begin
            wen[k]     = 1'b1;
            waddr[k]   = a;
            wdata[k]   = ~ev;
            nxt_err[k] = 1'b1;
         end else begin
            wen[k] = 1'b0;
         end
         cyc(k, 1'b0, ev, "rd_data");
      end
      wen[k] = 1'b0;
      if (!keep) req[k] = 1'b0;
   endtask

   initial begin
      logic [31:0] q [$];
      logic [31:0] a, d;
      for (int k = 0; k < 3; k++) begin
         rst[k]     = 1'b1;
         req[k]     = 1'b0;
         wen[k]     = 1'b0;
         waddr[k]   = 32'h0;
         wdata[k]   = 32'h0;
         raddr[k]   = 32'h0;
         exp_err[k] = 1'b0;
         nxt_err[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;

      for (int k = 0; k < 3; k++) begin
         idle(k, 1);
         // basic write then read with wait states
         wr(k, 32'h1000_0010, 32'hDEAD_BEEF);
         idle(k, 1);
         rd(k, 32'h1000_0010, 0, 0);
         // read right after write; byte offset ignored
         wr(k, 32'h1000_0020, 32'h1234_5678);
         rd(k, 32'h1000_0020, 0, 0);
         rd(k, 32'h1000_0023, 0, 0);
         // out-of-range read and write
         wr(k, 32'h1000_0000, 32'hA5A5_0000 + k);
         rd(k, 32'h2000_0000, 0, 0);
         idle(k, 2);
         wr(k, 32'h0000_0000, 32'hFFFF_FFFF);
         idle(k, 2);
         rd(k, 32'h1000_0000, 0, 0);
         rd(k, 32'h1000_0010, 0, 0);
         rd(k, 32'h1000_0020, 0, 0);
         // write while stalled is ignored and flagged
         rd(k, 32'h1000_0010, 0, 1);
         idle(k, 1);
         rd(k, 32'h1000_0010, 0, 0);
         // write coinciding with reset is dropped
         rst[k]   = 1'b1;
         req[k]   = 1'b1;
         wen[k]   = 1'b1;
         waddr[k] = 32'h1000_0020;
         wdata[k] = 32'h0BAD_0BAD;
         cyc(k, 1'b0, 32'h0, "wr_rst");
         rst[k] = 1'b0;
         idle(k, 1);
         rd(k, 32'h1000_0020, 0, 0);
         // reset in the middle of a stalled read
         if (wt[k] > 0) begin
            req[k]   = 1'b1;
            wen[k]   = 1'b0;
            raddr[k] = 32'h1000_0010;
            cyc(k, 1'b1, 32'h0, "rr_req");
            rst[k] = 1'b1;
            cyc(k, 1'b1, 32'h0, "rr_wait");
            rst[k] = 1'b0;
            idle(k, wt[k] + 1);
            rd(k, 32'h1000_0020, 0, 0);
         end
         // back-to-back reads with request held through completion
         rd(k, 32'h1000_0010, 1, 0);
         rd(k, 32'h1000_0020, 0, 0);
         idle(k, 1);
         // randomized write/read traffic
         q.delete();
         for (int i = 0; i < 10; i++) begin
            a = 32'h1000_0000 | (32'($urandom_range(0, 63)) << 2);
            d = $urandom;
            wr(k, a, d);
            q.push_back(a);
            a = q[$urandom_range(0, q.size() - 1)];
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a ^ 32'h0000_4000;
            rd(k, a, $urandom_range(0, 1) == 1 && in_rng(a), 0);
            idle(k, 1);
         end
         idle(k, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscmp);
      $finish;
   end

endmodule

// File: doc/core_dmem_slave.md
Name: core_dmem_slave

Overview:
- Data-side memory responder: the far end of the core's data port (mem_req/mem_wen/mem_waddr/mem_wdata/mem_raddr/mem_rdata) and the source of the core's bus hold_flag input.
- Backed by a synchronous-read word RAM with a programmable wait-state count.
- Reads are stretched by asserting hold until data is ready. Writes are posted and complete with zero wait.
- Sits between the core top and the SoC data RAM region.

Parameters:
- ADDR_W, 12, word-address width; RAM depth = 2^ADDR_W words of 32 bits.
- WAIT_CYC, 1, extra read wait cycles after the RAM access cycle (legal 0..15).
- BASE_ADDR, 32'h1000_0000, base byte address of the decoded region.
- ADDR_MASK, 32'h0000_3FFF, byte-offset mask. An address is in range iff (addr & ~ADDR_MASK) == BASE_ADDR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_req_i  in  1  access request from core.
- mem_wen_i  in  1  1 = write, 0 = read; valid when mem_req_i is high.
- mem_waddr_i  in  32  write byte address.
- mem_wdata_i  in  32  write data (full word).
- mem_raddr_i  in  32  read byte address.
- mem_rdata_o  out  32  read data to core.
- hold_flag_o  out  1  stall request to core (bus hold).
- err_o  out  1  one-cycle pulse on an out-of-range access or an illegal request.

Behaviour:
- Word index is addr[ADDR_W+1:2]; addr[1:0] is ignored (aligned word access only). RAM contents are not reset.
- State machine has three states: IDLE, WAIT, RESP. An internal 4-bit wait counter wcnt runs alongside it.
- IDLE, in-range write (mem_req_i & mem_wen_i): RAM[waddr] <= wdata at this edge; hold_flag_o = 0; stay in IDLE.
- IDLE, in-range read (mem_req_i & ~mem_wen_i):
  - hold_flag_o = 1 combinationally in the same cycle.
  - Latch the word index and issue the RAM read.
  - Go to WAIT with wcnt <= WAIT_CYC-1 if WAIT_CYC > 0, else go directly to RESP.
- WAIT: hold_flag_o = 1; wcnt decrements each cycle; go to RESP when wcnt == 0.
- RESP:
  - hold_flag_o = 0; mem_rdata_o = captured RAM word.
  - The core completes the read this cycle. The request still visible on the ports is the one being completed and must not start a new transaction.
  - Return to IDLE unconditionally.
- Read latency: request in cycle T. hold_flag_o is high for cycles T..T+WAIT_CYC. Data is valid in cycle T+1+WAIT_CYC.
- mem_rdata_o is 0 in every state except RESP.
- Out-of-range in IDLE:
  - Read: no hold; mem_rdata_o = 0; err_o = 1 in cycle T+1.
  - Write: RAM unchanged; err_o = 1 in cycle T+1.
- A write request seen in WAIT or RESP (illegal while the core is stalled) is ignored and sets err_o = 1 the next cycle.
- A write in cycle T followed by a read of the same address in T+1 returns the new data.
- Back-to-back reads: the second read starts in the IDLE cycle after RESP and pays the full latency again.
- Reset, values after the rst edge: state = IDLE, wcnt = 0, captured data = 0, err_o = 0, hold_flag_o = 0 (with no request), mem_rdata_o = 0.
- Reset mid-read (in WAIT or RESP): the transaction is abandoned; no data is returned; hold_flag_o drops after the reset edge.
- rst has priority over every request in the same cycle. A write coinciding with rst is dropped.

Test Plan:
- WAIT_CYC=1: write 0xDEADBEEF to 0x1000_0010, then read 0x1000_0010 at T → hold high in T and T+1, mem_rdata_o = 0xDEADBEEF in T+2, hold low in T+2.
- WAIT_CYC=0: read at T → hold high only in T, data in T+1. WAIT_CYC=3 → hold in T..T+3, data in T+4.
- Write 0x12345678 to 0x1000_0020 at T, read the same address at T+1 → returns 0x12345678. An address with [1:0]=2'b11 hits the same word.
- Read 0x2000_0000 → no hold, mem_rdata_o = 0, err_o pulses one cycle. Write 0x0000_0000 → RAM unchanged (read-back of all touched words unchanged), err_o pulse.
- Assert rst during WAIT (WAIT_CYC=3) → state IDLE, hold 0, mem_rdata_o 0 after the edge. A following read behaves normally.
- Two consecutive reads with the request held through RESP → exactly two transactions, each returning its own address's data, with no extra hold cycle.
